// File: rtl/arbitro_hamming_pkg.sv
// Shared definitions for the Hamming(15,11) arbiter: FSM encoding, codeword
// geometry and the id-width helper.
package arbitro_hamming_pkg;

  typedef enum logic [1:0] {
    OCIOSO     = 2'd0,
    DECODIFICA = 2'd1,
    RESPOSTA   = 2'd2
  } estado_t;

  localparam int CW_W   = 15;
  localparam int DATA_W = 11;

  // Zero-based bit index of each parity position (Hamming positions 1, 2, 4, 8).
  localparam int PARITY_POS [4] = '{0, 1, 3, 7};

  // Codeword bit feeding each data bit, LSB first: {c[14:8], c[6:4], c[2]}.
  localparam int DATA_IDX [11] = '{2, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14};

  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arbitro_hamming_if.sv
// Requester/consumer bundle of the Hamming arbiter; slave = the arbiter side.
// Handshake: req_ready is a one-cycle grant pulse, the codeword is taken while
// req_valid && req_ready; a response is consumed in the cycle resp_valid && resp_ack.
interface arbitro_hamming_if #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 16
) ();
  import arbitro_hamming_pkg::*;

  localparam int IDW = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]      req_valid;
  logic [CW_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]      req_ready;
  logic                    resp_valid;
  logic [IDW-1:0]          resp_id;
  logic [DATA_W-1:0]       resp_data;
  logic                    resp_corrigido;
  logic                    resp_ack;
  logic [CNT_W-1:0]        err_count;
  logic                    clr_count;
  estado_t                 estado;

  modport slave (
    input  req_valid, req_data, resp_ack, clr_count,
    output req_ready, resp_valid, resp_id, resp_data, resp_corrigido, err_count, estado
  );

  modport master (
    output req_valid, req_data, resp_ack, clr_count,
    input  req_ready, resp_valid, resp_id, resp_data, resp_corrigido, err_count, estado
  );

endinterface

// File: rtl/arbitro_hamming_rr_arbitro.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping
// at NUM_REQ (which need not be a power of two).
module rr_arbitro
  import arbitro_hamming_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDW    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDW-1:0]     gnt_idx
);

  logic           achou;
  logic [IDW:0]   soma;
  logic [IDW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    achou   = 1'b0;
    soma    = '0;
    idx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      soma = {1'b0, ptr} + (IDW+1)'(i);
      if (soma >= (IDW+1)'(NUM_REQ)) soma = soma - (IDW+1)'(NUM_REQ);
      idx = soma[IDW-1:0];
      if (!achou && req[idx]) begin
        achou      = 1'b1;
        gnt[idx]   = 1'b1;
        gnt_idx    = idx;
      end
    end
  end

endmodule

// File: rtl/arbitro_hamming.sv
// Shares one Hamming(15,11) single-error corrector among NUM_REQ requesters,
// one codeword in flight, with a saturating count of corrected words.
module arbitro_hamming
  import arbitro_hamming_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 16
) (
  input logic               clk,
  input logic               rst,
  arbitro_hamming_if.slave  bus
);

  localparam int IDW = id_width(NUM_REQ);

  estado_t             estado, prox;
  logic [IDW-1:0]      ptr, id_q, gnt_idx, resp_id_q;
  logic [NUM_REQ-1:0]  gnt;
  logic [CW_W-1:0]     w_q, c;
  logic [CW_W-1:0]     fatia [NUM_REQ];
  logic [3:0]          pos;
  logic [DATA_W-1:0]   dado, resp_data_q;
  logic                resp_corr_q;
  logic [CNT_W-1:0]    err_cnt;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_fatia
    assign fatia[k] = bus.req_data[CW_W*k +: CW_W];
  end

  rr_arbitro #(.NUM_REQ(NUM_REQ)) u_rr (
    .req     (bus.req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) estado <= OCIOSO;
    else     estado <= prox;
  end

  always_comb begin
    prox = estado;
    case (estado)
      OCIOSO:     if (|bus.req_valid) prox = DECODIFICA;
      DECODIFICA: prox = RESPOSTA;
      RESPOSTA:   if (bus.resp_ack) prox = OCIOSO;
      default:    prox = OCIOSO;
    endcase
  end

  // The grant is masked during reset so req_ready reads 0 while rst is high.
  always_comb begin
    bus.req_ready  = '0;
    if (estado == OCIOSO && !rst) bus.req_ready = gnt;
    bus.resp_valid = (estado == RESPOSTA);
    bus.estado     = estado;
  end

  // Syndrome bit j covers every position whose index has the bit of parity position j set.
  always_comb begin
    pos = '0;
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < CW_W; i++) begin
        if (((i + 1) & (PARITY_POS[j] + 1)) != 0) pos[j] = pos[j] ^ w_q[i];
      end
    end
    c = w_q;
    if (pos != 4'd0) c[pos - 4'd1] = ~c[pos - 4'd1];
    dado = '0;
    for (int k = 0; k < DATA_W; k++) dado[k] = c[DATA_IDX[k]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr         <= '0;
      id_q        <= '0;
      w_q         <= '0;
      resp_id_q   <= '0;
      resp_data_q <= '0;
      resp_corr_q <= 1'b0;
    end else begin
      case (estado)
        OCIOSO: if (|bus.req_valid) begin
          w_q  <= fatia[gnt_idx];
          id_q <= gnt_idx;
        end
        DECODIFICA: begin
          resp_data_q <= dado;
          resp_corr_q <= (pos != 4'd0);
          resp_id_q   <= id_q;
        end
        RESPOSTA: if (bus.resp_ack) begin
          if (resp_id_q == IDW'(NUM_REQ - 1)) ptr <= '0;
          else                                ptr <= resp_id_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Clear has priority over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                   err_cnt <= '0;
    else if (bus.clr_count)                                    err_cnt <= '0;
    else if (estado == DECODIFICA && pos != 4'd0 && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
  end

  assign bus.resp_id        = resp_id_q;
  assign bus.resp_data      = resp_data_q;
  assign bus.resp_corrigido = resp_corr_q;
  assign bus.err_count      = err_cnt;

endmodule

// File: tb/tb_arbitro_hamming.sv
// Directed bench for arbitro_hamming: a 16-bit-counter instance and a 2-bit-counter
// instance driven with identical stimulus.
module tb_arbitro_hamming;
  import arbitro_hamming_pkg::*;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  arbitro_hamming_if #(.NUM_REQ(4), .CNT_W(16)) bus ();
  arbitro_hamming_if #(.NUM_REQ(4), .CNT_W(2))  bus2 ();

  assign bus2.req_valid = bus.req_valid;
  assign bus2.req_data  = bus.req_data;
  assign bus2.resp_ack  = bus.resp_ack;
  assign bus2.clr_count = bus.clr_count;

  arbitro_hamming #(.NUM_REQ(4), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  arbitro_hamming #(.NUM_REQ(4), .CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.resp_ack  = 1'b0;
    bus.clr_count = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_chk++; if (bus.estado !== OCIOSO) $display("FAIL reset_state got %0d want %0d", bus.estado, OCIOSO); else n_pass++;
    n_chk++; if (bus.req_ready !== 4'b0000 || bus.resp_valid !== 1'b0) $display("FAIL reset_handshake got ready=%b valid=%b want 0000/0", bus.req_ready, bus.resp_valid); else n_pass++;
    n_chk++; if (bus.resp_id !== 2'd0 || bus.resp_data !== 11'h000 || bus.resp_corrigido !== 1'b0) $display("FAIL reset_resp got id=%0d data=%h corr=%b want 0/000/0", bus.resp_id, bus.resp_data, bus.resp_corrigido); else n_pass++;
    n_chk++; if (bus.err_count !== 16'd0 || bus2.err_count !== 2'd0) $display("FAIL reset_count got %0d/%0d want 0/0", bus.err_count, bus2.err_count); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [3:0] er;
    @(negedge clk); #1;
    bus.req_data  = '0;
    bus.req_valid = 4'b1111;
    bus.resp_ack  = 1'b1;
    #1;
    for (int c = 0; c < 13; c++) begin
      er = (c % 3 == 0) ? (4'b0001 << ((c / 3) % 4)) : 4'b0000;
      n_chk++; if (bus.req_ready !== er) $display("FAIL b2b_grant cycle=%0d got %b want %b", c, bus.req_ready, er); else n_pass++;
      if (c % 3 == 2) begin
        n_chk++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'((c / 3) % 4)) $display("FAIL b2b_resp cycle=%0d got valid=%b id=%0d want 1/%0d", c, bus.resp_valid, bus.resp_id, (c / 3) % 4); else n_pass++;
      end
      if (c < 12) begin
        @(negedge clk); #1;
      end
    end
    @(negedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk);
    @(negedge clk); #1;
    bus.resp_ack = 1'b0;
  endtask

  task automatic send(input int id, input logic [14:0] w, input logic [10:0] exp_d,
                      input logic exp_c, input int exp_cnt);
    logic [3:0] exp_rdy;
    exp_rdy = 4'b0001 << id;
    @(negedge clk); #1;
    bus.req_data = '0;
    bus.req_data[15*id +: 15] = w;
    bus.req_valid = exp_rdy;
    #1;
    n_chk++; if (bus.req_ready !== exp_rdy) $display("FAIL send_grant id=%0d got %b want %b", id, bus.req_ready, exp_rdy); else n_pass++;
    @(negedge clk); #1;
    bus.req_valid = '0;
    n_chk++; if (bus.estado !== DECODIFICA || bus.resp_valid !== 1'b0) $display("FAIL send_decode id=%0d got state=%0d valid=%b want %0d/0", id, bus.estado, bus.resp_valid, DECODIFICA); else n_pass++;
    @(negedge clk); #1;
    n_chk++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'(id)) $display("FAIL send_resp id=%0d got valid=%b id=%0d want 1/%0d", id, bus.resp_valid, bus.resp_id, id); else n_pass++;
    n_chk++; if (bus.resp_data !== exp_d || bus.resp_corrigido !== exp_c) $display("FAIL send_data word=%h got %h/%b want %h/%b", w, bus.resp_data, bus.resp_corrigido, exp_d, exp_c); else n_pass++;
    n_chk++; if (bus.err_count !== 16'(exp_cnt)) $display("FAIL send_count word=%h got %0d want %0d", w, bus.err_count, exp_cnt); else n_pass++;
    n_chk++; if (bus2.err_count !== 2'((exp_cnt > 3) ? 3 : exp_cnt)) $display("FAIL send_sat word=%h got %0d want %0d", w, bus2.err_count, (exp_cnt > 3) ? 3 : exp_cnt); else n_pass++;
    bus.resp_ack = 1'b1;
    @(negedge clk); #1;
    bus.resp_ack = 1'b0;
    n_chk++; if (bus.resp_valid !== 1'b0) $display("FAIL send_drop id=%0d got %b want 0", id, bus.resp_valid); else n_pass++;
  endtask

  task automatic test_decode;
    send(0, 15'h0000, 11'h000, 1'b0, 0);
    send(2, 15'h7FDF, 11'h7FF, 1'b1, 1);
    send(1, 15'h0001, 11'h000, 1'b1, 2);
    send(3, 15'h0007, 11'h001, 1'b0, 2);
    send(0, 15'h0004, 11'h000, 1'b1, 3);
    send(2, 15'h0003, 11'h001, 1'b1, 4);
    send(3, 15'h4000, 11'h000, 1'b1, 5);
  endtask

  // Pointer sits at 0 here (last response came from requester 3).
  task automatic test_hold;
    @(negedge clk); #1;
    bus.req_data = '0;
    bus.req_data[14:0] = 15'h7FDF;
    bus.req_valid = 4'b0011;
    #1;
    n_chk++; if (bus.req_ready !== 4'b0001) $display("FAIL hold_grant got %b want 0001", bus.req_ready); else n_pass++;
    @(negedge clk); #1;
    bus.req_valid = 4'b0010;
    @(negedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      n_chk++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd0 || bus.resp_data !== 11'h7FF || bus.resp_corrigido !== 1'b1)
        $display("FAIL hold_stable k=%0d got %b/%0d/%h/%b want 1/0/7ff/1", k, bus.resp_valid, bus.resp_id, bus.resp_data, bus.resp_corrigido);
      else n_pass++;
      n_chk++; if (bus.req_ready !== 4'b0000) $display("FAIL hold_ready k=%0d got %b want 0000", k, bus.req_ready); else n_pass++;
      @(negedge clk); #1;
    end
    n_chk++; if (bus.err_count !== 16'd6 || bus2.err_count !== 2'd3) $display("FAIL hold_count got %0d/%0d want 6/3", bus.err_count, bus2.err_count); else n_pass++;
    bus.resp_ack = 1'b1;
    #1;
    n_chk++; if (bus.req_ready !== 4'b0000) $display("FAIL hold_ack_ready got %b want 0000", bus.req_ready); else n_pass++;
    @(negedge clk); #1;
    bus.resp_ack = 1'b0;
    n_chk++; if (bus.req_ready !== 4'b0010) $display("FAIL hold_next_grant got %b want 0010", bus.req_ready); else n_pass++;
    @(negedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk); #1;
    n_chk++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd1 || bus.resp_data !== 11'h000 || bus.resp_corrigido !== 1'b0)
      $display("FAIL hold_second got %b/%0d/%h/%b want 1/1/000/0", bus.resp_valid, bus.resp_id, bus.resp_data, bus.resp_corrigido);
    else n_pass++;
    bus.resp_ack = 1'b1;
    @(negedge clk); #1;
    bus.resp_ack = 1'b0;
  endtask

  task automatic test_clr_collision;
    @(negedge clk); #1;
    bus.req_data = '0;
    bus.req_data[29:15] = 15'h0001;
    bus.req_valid = 4'b0010;
    #1;
    n_chk++; if (bus.req_ready !== 4'b0010) $display("FAIL clr_grant got %b want 0010", bus.req_ready); else n_pass++;
    @(negedge clk); #1;
    bus.req_valid = '0;
    bus.clr_count = 1'b1;
    @(negedge clk); #1;
    bus.clr_count = 1'b0;
    n_chk++; if (bus.resp_corrigido !== 1'b1) $display("FAIL clr_corr got %b want 1", bus.resp_corrigido); else n_pass++;
    n_chk++; if (bus.err_count !== 16'd0 || bus2.err_count !== 2'd0) $display("FAIL clr_count got %0d/%0d want 0/0", bus.err_count, bus2.err_count); else n_pass++;
    bus.resp_ack = 1'b1;
    @(negedge clk); #1;
    bus.resp_ack = 1'b0;
  endtask

  // Pointer is 2 before this; 4'b1001 after reset must grant 0, not 3.
  task automatic test_reset_mid;
    @(negedge clk); #1;
    bus.req_data = '0;
    bus.req_data[44:30] = 15'h7FDF;
    bus.req_valid = 4'b0100;
    #1;
    n_chk++; if (bus.req_ready !== 4'b0100) $display("FAIL rmid_grant got %b want 0100", bus.req_ready); else n_pass++;
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    n_chk++; if (bus.estado !== OCIOSO || bus.req_ready !== 4'b0000) $display("FAIL rmid_state got %0d/%b want %0d/0000", bus.estado, bus.req_ready, OCIOSO); else n_pass++;
    bus.req_valid = '0;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      n_chk++; if (bus.resp_valid !== 1'b0 || bus.resp_data !== 11'h000 || bus.resp_corrigido !== 1'b0)
        $display("FAIL rmid_noresp k=%0d got %b/%h/%b want 0/000/0", k, bus.resp_valid, bus.resp_data, bus.resp_corrigido);
      else n_pass++;
    end
    n_chk++; if (bus.err_count !== 16'd0) $display("FAIL rmid_count got %0d want 0", bus.err_count); else n_pass++;
    bus.req_data = '0;
    bus.req_valid = 4'b1001;
    #1;
    n_chk++; if (bus.req_ready !== 4'b0001) $display("FAIL rmid_ptr got %b want 0001", bus.req_ready); else n_pass++;
    @(negedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk); #1;
    n_chk++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd0) $display("FAIL rmid_resp got %b/%0d want 1/0", bus.resp_valid, bus.resp_id); else n_pass++;
    bus.resp_ack = 1'b1;
    @(negedge clk); #1;
    bus.resp_ack = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    test_reset();
    test_back_to_back();
    test_decode();
    test_hold();
    test_clr_collision();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/arbitro_hamming.md
Name: arbitro_hamming

Overview:
Sequences a single Hamming(15,11) single-error-correction datapath and shares it among NUM_REQ requesters. Round-robin arbitration; one codeword in flight at a time. Each request gets the corrected 11-bit data word, a "corrected" flag and the requester id. A saturating counter tracks how many codewords needed correction. Sits between the word sources (receive channels, memory readers) and the consumers of corrected data.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
CNT_W, 16, width of the corrected-word counter
(localparam IDW = max(1, $clog2(NUM_REQ)))

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
req_valid  input  NUM_REQ  bit k: requester k has a codeword pending
req_data  input  15*NUM_REQ  requester k codeword at [15k+14:15k]; bit i = Hamming position i+1
req_ready  output  NUM_REQ  one-hot grant pulse; the codeword is accepted in that cycle
resp_valid  output  1  response available
resp_id  output  IDW  requester id of the response
resp_data  output  11  corrected data {c[14:8], c[6:4], c[2]}
resp_corrigido  output  1  1 if the syndrome was nonzero
resp_ack  input  1  consumer takes the response
err_count  output  CNT_W  saturating count of words with nonzero syndrome
clr_count  input  1  synchronous clear of err_count

Behaviour:
- Reset (async, rst=1): state OCIOSO; rr pointer 0; req_ready, resp_valid, resp_id, resp_data, resp_corrigido and err_count all 0. A transaction in flight is dropped with no response.
- FSM OCIOSO -> DECODIFICA -> RESPOSTA -> OCIOSO.
- OCIOSO: if any req_valid, grant g = first k with req_valid[k], searching from pointer upward with wrap. req_ready[g]=1 combinationally in this cycle only. Latch req_data slice g and id g. Next state DECODIFICA. If no requests, stay. req_ready is 0 in all other states.
- Syndrome s0..s3 on the latched word w. s_j = XOR of w[i] for every i where bit j of (i+1) is set. pos = {s3,s2,s1,s0}.
- Correction: if pos != 0, c = w with bit (pos-1) flipped; else c = w. A parity-bit error (pos = 1, 2, 4, 8) is corrected but does not change the data.
- DECODIFICA: register resp_data from c, resp_corrigido = (pos != 0), resp_id = latched id. If pos != 0, err_count += 1, saturating at all-ones. Next state RESPOSTA.
- RESPOSTA: resp_valid=1. resp_id, resp_data and resp_corrigido hold stable until resp_ack=1. On ack: resp_valid drops next cycle, pointer = (resp_id+1) mod NUM_REQ, next state OCIOSO.
- Latency: grant in cycle T -> resp_valid high from T+2. Minimum 3 cycles per word with ack tied high. The next grant comes in the cycle after ack.
- Double errors are not detected; they are miscorrected silently (SEC only).
- clr_count together with an increment in the same cycle: the clear wins, err_count = 0.
- req_valid dropping before grant: no grant and no state change. A requester must hold its data while valid and not ready.
- NUM_REQ not a power of two: the pointer wraps from NUM_REQ-1 to 0. Requester indices >= NUM_REQ are never generated.

Decomposition:
- Shared package: FSM state encoding (OCIOSO, DECODIFICA, RESPOSTA); constants for codeword width 15, data width 11, parity positions {0,1,3,7}, data-bit index list.
- Sub-module rr_arbitro (NUM_REQ): inputs req vector and pointer; outputs one-hot grant and its binary index; purely combinational.
- Syndrome and correction logic stay inline.

Test Plan:
- After reset, requester 0 sends 15'h0000 -> req_ready=4'b0001 in the same cycle; 2 cycles later resp_valid=1, resp_id=0, resp_data=11'h000, resp_corrigido=0; err_count=0.
- Requester 2 sends 15'h7FDF (15'h7FFF with bit 5 flipped) -> resp_data=11'h7FF, resp_corrigido=1, resp_id=2; err_count=1.
- Requester 1 sends 15'h0001 (parity position 1 flipped) -> resp_data=11'h000, resp_corrigido=1; err_count increments.
- All four req_valid=1 from reset with ack tied high -> grants in order 0, 1, 2, 3, 0, with 3 cycles between grants; no requester is granted twice before the others.
- resp_ack held low 5 cycles in RESPOSTA while other requests pend -> resp_* stable, req_ready=0 throughout; grant follows the cycle after ack.
- CNT_W=2: five erroneous words -> err_count 1, 2, 3, 3, 3. clr_count asserted in the same cycle as an increment -> err_count=0. rst pulsed in DECODIFICA -> no response, state OCIOSO, pointer 0.
